// File: rtl/ed25519_pkg.sv
// ed25519_pkg: field constants and point-adder state encoding for the edwards25519 group-add datapath.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package ed25519_pkg;

   localparam int FIELD_W = 256;

   // p = 2^255 - 19
   localparam logic [FIELD_W-1:0] P_MOD =
      256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

   // Twisted Edwards curve constant d (a = -1)
   localparam logic [FIELD_W-1:0] CURVE_D =
      256'h52036cee_2b6ffe73_8cc74079_7779e898_00700a4d_4141d8ab_75eb4dca_135978a3;

   // Multiply sequence: steps 0..11, the last one produces Z3
   localparam logic [3:0] LAST_STEP = 4'd11;

   typedef enum logic [2:0] {
      PA_IDLE,
      PA_LOAD,
      PA_MUL,
      PA_WAIT,
      PA_DONE
   } pa_state_t;

endpackage

// File: rtl/mod_mul.sv
// mod_mul: interleaved shift-add bit-serial multiplier mod p, result in [0, p).
// Latency: done pulses 258 cycles after the start edge (256 iterations + 2 reduction cycles).
// Backpressure: start is ignored while busy; result holds until the next done.
//
// Ports: clk, rst_n (async active-low), start (operands a/b sampled on that edge),
//        a, b (residues < p), result, done (one-cycle pulse with result valid).
module mod_mul
   import ed25519_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [FIELD_W-1:0] a,
   input  logic [FIELD_W-1:0] b,
   output logic [FIELD_W-1:0] result,
   output logic               done
);

   typedef enum logic [1:0] {MM_IDLE, MM_RUN, MM_RED1, MM_RED2} mm_state_t;

   localparam logic [FIELD_W+1:0] P1X = {2'b00, P_MOD};
   localparam logic [FIELD_W+1:0] P2X = {1'b0, P_MOD, 1'b0};

   mm_state_t          state;
   logic [FIELD_W-1:0] areg;
   logic [FIELD_W-1:0] breg;
   logic [FIELD_W-1:0] acc;
   logic [7:0]         cnt;
   logic [FIELD_W+1:0] t;
   logic [FIELD_W-1:0] acc_nxt;

   // One Horner step, MSB of b first: t = 2*acc + bit*a. With acc, a < p
   // the sum stays below 3p, so one compare against 2p or p brings it back.
   always_comb begin
      t = {1'b0, acc, 1'b0} + (breg[FIELD_W-1] ? {2'b00, areg} : '0);
      if (t >= P2X)
         acc_nxt = FIELD_W'(t - P2X);
      else if (t >= P1X)
         acc_nxt = FIELD_W'(t - P1X);
      else
         acc_nxt = FIELD_W'(t);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= MM_IDLE;
         areg   <= '0;
         breg   <= '0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            MM_IDLE: begin
               if (start) begin
                  areg  <= a;
                  breg  <= b;
                  acc   <= '0;
                  cnt   <= 8'd255;
                  state <= MM_RUN;
               end
            end
            MM_RUN: begin
               acc  <= acc_nxt;
               breg <= {breg[FIELD_W-2:0], 1'b0};
               cnt  <= cnt - 8'd1;
               if (cnt == 8'd0)
                  state <= MM_RED1;
            end
            MM_RED1: begin
               // Final canonicalisation; keeps the result in [0, p) even if
               // the iteration bound is ever loosened.
               if (acc >= P_MOD)
                  acc <= acc - P_MOD;
               state <= MM_RED2;
            end
            MM_RED2: begin
               result <= acc;
               done   <= 1'b1;
               state  <= MM_IDLE;
            end
            default: state <= MM_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/point_add.sv
// point_add: edwards25519 projective point adder (add-2008-bbjlp, a = -1) on one shared mod_mul.
// Latency: fixed, 12 multiplies x 260 cycles + 1 (3121 cycles); 11 multiplies (2861) with POINTADD_MIXED_EN.
// Backpressure: i_start is ignored while busy and in the DONE cycle; outputs hold until the next completion.
//
// Ports: i_clk, i_rst (async active-low), i_start (operands sampled on that edge),
//        i_x1/i_y1/i_z1, i_x2/i_y2/i_z2 (residues < p), o_x3/o_y3/o_z3, o_finished (one-cycle pulse).
// Build option: POINTADD_MIXED_EN -- mixed addition, i_z2 ignored and taken as 1, first multiply skipped.
module point_add
   import ed25519_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [FIELD_W-1:0] i_x1,
   input  logic [FIELD_W-1:0] i_y1,
   input  logic [FIELD_W-1:0] i_z1,
   input  logic [FIELD_W-1:0] i_x2,
   input  logic [FIELD_W-1:0] i_y2,
   input  logic [FIELD_W-1:0] i_z2,
   output logic [FIELD_W-1:0] o_x3,
   output logic [FIELD_W-1:0] o_y3,
   output logic [FIELD_W-1:0] o_z3,
   output logic               o_finished
);

   function automatic logic [FIELD_W-1:0] add_mod(input logic [FIELD_W-1:0] a,
                                                  input logic [FIELD_W-1:0] b);
      logic [FIELD_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, P_MOD})
         s = s - {1'b0, P_MOD};
      return s[FIELD_W-1:0];
   endfunction

   // Wraps mod 2^256 then adds p back; the true result fits in 256 bits.
   function automatic logic [FIELD_W-1:0] sub_mod(input logic [FIELD_W-1:0] a,
                                                  input logic [FIELD_W-1:0] b);
      logic [FIELD_W-1:0] d;
      d = a - b;
      if (a < b)
         d = d + P_MOD;
      return d;
   endfunction

`ifdef POINTADD_MIXED_EN
   localparam logic [3:0] FIRST_STEP = 4'd1;
   logic unused_z2;
   assign unused_z2 = ^i_z2;
`else
   localparam logic [3:0] FIRST_STEP = 4'd0;
   logic [FIELD_W-1:0] z1, z2;
`endif

   pa_state_t          state, state_nxt;
   logic [3:0]         step;
   logic [FIELD_W-1:0] x1, y1, x2, y2;
   logic [FIELD_W-1:0] ra, rb, rc, rd, re, rf, rg, rh, rt;
   logic [FIELD_W-1:0] mul_a, mul_b, mul_res;
   logic               mul_start, mul_done;

   mod_mul u_mul (
      .clk    (i_clk),
      .rst_n  (i_rst),
      .start  (mul_start),
      .a      (mul_a),
      .b      (mul_b),
      .result (mul_res),
      .done   (mul_done)
   );

   // State register
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)
         state <= PA_IDLE;
      else
         state <= state_nxt;
   end

   // Next state
   always_comb begin
      state_nxt = state;
      case (state)
         PA_IDLE: if (i_start) state_nxt = PA_LOAD;
         PA_LOAD: state_nxt = PA_MUL;
         PA_MUL:  state_nxt = PA_WAIT;
         PA_WAIT: if (mul_done) state_nxt = (step == LAST_STEP) ? PA_DONE : PA_MUL;
         PA_DONE: state_nxt = PA_IDLE;
         default: state_nxt = PA_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      mul_start  = (state == PA_MUL);
      o_finished = (state == PA_DONE);
   end

   // Multiplier operand select per step
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (step)
`ifdef POINTADD_MIXED_EN
`else
         4'd0:  begin mul_a = z1;                mul_b = z2;                end // A
`endif
         4'd1:  begin mul_a = ra;                mul_b = ra;                end // B
         4'd2:  begin mul_a = x1;                mul_b = x2;                end // C
         4'd3:  begin mul_a = y1;                mul_b = y2;                end // D
         4'd4:  begin mul_a = rc;                mul_b = rd;                end // C*D
         4'd5:  begin mul_a = CURVE_D;           mul_b = re;                end // E
         4'd6:  begin mul_a = add_mod(x1, y1);   mul_b = add_mod(x2, y2);   end // H'
         4'd7:  begin mul_a = ra;                mul_b = rf;                end // A*F
         4'd8:  begin mul_a = rt;                mul_b = rh;                end // X3
         4'd9:  begin mul_a = ra;                mul_b = rg;                end // A*G
         4'd10: begin mul_a = rt;                mul_b = add_mod(rd, rc);   end // Y3
         4'd11: begin mul_a = rf;                mul_b = rg;                end // Z3
         default: ;
      endcase
   end

   // Operand copies and per-step write-back. rh is reused for X3 and rt for Y3
   // once H and the A*F / A*G products have been consumed.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         step <= '0;
         x1 <= '0; y1 <= '0; x2 <= '0; y2 <= '0;
`ifdef POINTADD_MIXED_EN
`else
         z1 <= '0; z2 <= '0;
`endif
         ra <= '0; rb <= '0; rc <= '0; rd <= '0; re <= '0;
         rf <= '0; rg <= '0; rh <= '0; rt <= '0;
         o_x3 <= '0; o_y3 <= '0; o_z3 <= '0;
      end else begin
         if (state == PA_IDLE && i_start) begin
            x1   <= i_x1;
            y1   <= i_y1;
            x2   <= i_x2;
            y2   <= i_y2;
            step <= FIRST_STEP;
`ifdef POINTADD_MIXED_EN
            ra   <= i_z1;
`else
            z1   <= i_z1;
            z2   <= i_z2;
`endif
         end
         if (state == PA_WAIT && mul_done) begin
            step <= step + 4'd1;
            case (step)
               4'd0:  ra <= mul_res;
               4'd1:  rb <= mul_res;
               4'd2:  rc <= mul_res;
               4'd3:  rd <= mul_res;
               4'd4:  re <= mul_res;
               4'd5: begin
                  re <= mul_res;
                  rf <= sub_mod(rb, mul_res);
                  rg <= add_mod(rb, mul_res);
               end
               4'd6:  rh <= sub_mod(sub_mod(mul_res, rc), rd);
               4'd7:  rt <= mul_res;
               4'd8:  rh <= mul_res;
               4'd9:  rt <= mul_res;
               4'd10: rt <= mul_res;
               4'd11: begin
                  o_x3 <= rh;
                  o_y3 <= rt;
                  o_z3 <= mul_res;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_point_add.sv
// tb_point_add: randomized and directed checks of point_add against a field-arithmetic model.
// Latency: measured per run; must be identical for every vector and at most 3200 cycles.
// Backpressure: exercises ignored i_start while busy and in the DONE cycle.
module tb_point_add;

   typedef logic [255:0] f_t;

   localparam f_t P  = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
   localparam f_t DC = 256'h52036cee_2b6ffe73_8cc74079_7779e898_00700a4d_4141d8ab_75eb4dca_135978a3;
`ifdef POINTADD_MIXED_EN
   localparam bit MIXED = 1'b1;
`else
   localparam bit MIXED = 1'b0;
`endif

   localparam f_t GX  = 256'd7075909580202862594128302673554914659407030209928197693208324339654829354926;
   localparam f_t GY  = 256'd21286769175881002626746167682496214460774588269525023793279114113306181287586;
   localparam f_t P1X = 256'd51169388680954780618255949183088705830597642531673777941256840852923233932582;
   localparam f_t P1Y = 256'd38023371316134590270444440476521181483750022538757642829225406787274294448402;
   localparam f_t P1Z = 256'd47908574844383975721735585330619112154511882220818545990695845831320904662833;

   logic i_clk, i_rst, i_start;
   f_t   i_x1, i_y1, i_z1, i_x2, i_y2, i_z2;
   f_t   o_x3, o_y3, o_z3;
   logic o_finished;

   int n_checks = 0;
   int n_pass   = 0;
   int fin_cnt  = 0;
   int lat_ref  = -1;

   point_add dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
      .i_x1(i_x1), .i_y1(i_y1), .i_z1(i_z1),
      .i_x2(i_x2), .i_y2(i_y2), .i_z2(i_z2),
      .o_x3(o_x3), .o_y3(o_y3), .o_z3(o_z3),
      .o_finished(o_finished)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) if (o_finished === 1'b1) fin_cnt <= fin_cnt + 1;

   // ---------------- field arithmetic reference ----------------
   function automatic f_t mm(input f_t a, input f_t b);
      logic [511:0] t;
      t = {256'd0, a} * {256'd0, b};
      t = t % {256'd0, P};
      return t[255:0];
   endfunction

   function automatic f_t ad(input f_t a, input f_t b);
      logic [256:0] s;
      s = ({1'b0, a} + {1'b0, b}) % {1'b0, P};
      return s[255:0];
   endfunction

   function automatic f_t sb(input f_t a, input f_t b);
      return ad(a, P - b);
   endfunction

   function automatic bit on_curve(input f_t x, input f_t y, input f_t z);
      f_t xx, yy, zz, lhs, rhs;
      xx  = mm(x, x); yy = mm(y, y); zz = mm(z, z);
      lhs = mm(sb(yy, xx), zz);
      rhs = ad(mm(zz, zz), mm(DC, mm(xx, yy)));
      return lhs == rhs;
   endfunction

   task automatic model(input f_t x1, y1, z1, x2, y2, z2, output f_t x3, y3, z3);
      f_t a, b, c, d, e, f, g, h, zz2;
      zz2 = MIXED ? 256'd1 : z2;
      a = mm(z1, zz2);
      b = mm(a, a);
      c = mm(x1, x2);
      d = mm(y1, y2);
      e = mm(DC, mm(c, d));
      f = sb(b, e);
      g = ad(b, e);
      h = sb(sb(mm(ad(x1, y1), ad(x2, y2)), c), d);
      x3 = mm(mm(a, f), h);
      y3 = mm(mm(a, g), ad(d, c));
      z3 = mm(f, g);
   endtask

   function automatic f_t rnd_fe();
      f_t r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r % P;
   endfunction

   task automatic drive(input f_t x1, y1, z1, x2, y2, z2);
      i_x1 = x1; i_y1 = y1; i_z1 = z1;
      i_x2 = x2; i_y2 = y2; i_z2 = z2;
   endtask

   // One computation; inputs are scrambled right after the start edge.
   task automatic run_op(input f_t ax1, ay1, az1, ax2, ay2, az2,
                         output f_t rx, ry, rz, output int lat);
      int c0;
      bit got;
      c0 = fin_cnt;
      @(negedge i_clk);
      drive(ax1, ay1, az1, ax2, ay2, az2);
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      drive(rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe());
      lat = 0; got = 1'b0;
      while (!got && lat < 4000) begin
         @(negedge i_clk);
         lat++;
         if (o_finished === 1'b1) got = 1'b1;
      end
      rx = o_x3; ry = o_y3; rz = o_z3;
      n_checks++;
      if (!got) $display("FAIL run_timeout: no o_finished within %0d cycles, required <= 3200", lat);
      else n_pass++;
      @(negedge i_clk);
      n_checks++;
      if (o_finished !== 1'b0) $display("FAIL finished_width: o_finished=%b next cycle, required 0", o_finished);
      else n_pass++;
      n_checks++;
      if (fin_cnt - c0 !== 1) $display("FAIL finished_count: %0d pulses, required 1", fin_cnt - c0);
      else n_pass++;
   endtask

   task automatic check_result(input string nm, input f_t gx, gy, gz, input f_t ex, ey, ez);
      n_checks++;
      if (gx !== ex) $display("FAIL %s_x3: got %h required %h", nm, gx, ex); else n_pass++;
      n_checks++;
      if (gy !== ey) $display("FAIL %s_y3: got %h required %h", nm, gy, ey); else n_pass++;
      n_checks++;
      if (gz !== ez) $display("FAIL %s_z3: got %h required %h", nm, gz, ez); else n_pass++;
   endtask

   task automatic check_lat(input string nm, input int lat);
      n_checks++;
      if (lat !== lat_ref) $display("FAIL %s_latency: got %0d required %0d", nm, lat, lat_ref);
      else n_pass++;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      i_rst = 1'b0; i_start = 1'b0;
      drive(rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe());
      repeat (4) @(negedge i_clk);
      check_result("reset", o_x3, o_y3, o_z3, 256'd0, 256'd0, 256'd0);
      n_checks++;
      if (o_finished !== 1'b0) $display("FAIL reset_finished: got %b required 0", o_finished);
      else n_pass++;
      i_rst = 1'b1;
      repeat (2) @(negedge i_clk);
   endtask

   task automatic test_identity_left();
      f_t rx, ry, rz; int lat;
      run_op(256'd0, 256'd1, 256'd1, GX, GY, 256'd1, rx, ry, rz, lat);
      check_result("identity_left", rx, ry, rz, GX, GY, 256'd1);
      lat_ref = lat;
      n_checks++;
      if (lat < 1 || lat > 3200) $display("FAIL latency_bound: got %0d required 1..3200", lat);
      else n_pass++;
   endtask

   task automatic test_identity_right();
      f_t rx, ry, rz; int lat;
      run_op(GX, GY, 256'd1, 256'd0, 256'd1, 256'd1, rx, ry, rz, lat);
      check_result("identity_right", rx, ry, rz, GX, GY, 256'd1);
      check_lat("identity_right", lat);
   endtask

   task automatic test_general_add();
      f_t rx, ry, rz, ex, ey, ez; int lat;
      model(P1X, P1Y, P1Z, GX, GY, 256'd1, ex, ey, ez);
      run_op(P1X, P1Y, P1Z, GX, GY, 256'd1, rx, ry, rz, lat);
      check_result("general", rx, ry, rz, ex, ey, ez);
      check_lat("general", lat);
      if (on_curve(P1X, P1Y, P1Z) && on_curve(GX, GY, 256'd1)) begin
         n_checks++;
         if (!on_curve(rx, ry, rz)) $display("FAIL general_on_curve: got off-curve (%h:%h:%h) required on-curve", rx, ry, rz);
         else n_pass++;
      end
   endtask

   task automatic test_doubling();
      f_t rx, ry, rz, ex, ey, ez; int lat;
      model(P1X, P1Y, P1Z, P1X, P1Y, P1Z, ex, ey, ez);
      run_op(P1X, P1Y, P1Z, P1X, P1Y, P1Z, rx, ry, rz, lat);
      check_result("double", rx, ry, rz, ex, ey, ez);
      check_lat("double", lat);
   endtask

   task automatic test_random();
      f_t v[6]; f_t rx, ry, rz, ex, ey, ez; int lat;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 6; i++) v[i] = rnd_fe();
         if (k == 0) v[5] = 256'd1;
         model(v[0], v[1], v[2], v[3], v[4], v[5], ex, ey, ez);
         run_op(v[0], v[1], v[2], v[3], v[4], v[5], rx, ry, rz, lat);
         check_result("random", rx, ry, rz, ex, ey, ez);
         check_lat("random", lat);
      end
   endtask

   task automatic test_busy_start();
      f_t a[6]; f_t ex, ey, ez; int lat, c0; bit got;
      for (int i = 0; i < 6; i++) a[i] = rnd_fe();
      model(a[0], a[1], a[2], a[3], a[4], a[5], ex, ey, ez);
      c0 = fin_cnt;
      @(negedge i_clk);
      drive(a[0], a[1], a[2], a[3], a[4], a[5]);
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      drive(rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe());
      lat = 0; got = 1'b0;
      while (!got && lat < 4000) begin
         @(negedge i_clk);
         lat++;
         if (lat == 100) i_start = 1'b1;
         if (lat == 101) i_start = 1'b0;
         if (o_finished === 1'b1) got = 1'b1;
      end
      i_start = 1'b0;
      n_checks++;
      if (!got) $display("FAIL busy_timeout: no o_finished within %0d cycles, required <= 3200", lat);
      else n_pass++;
      check_result("busy_start", o_x3, o_y3, o_z3, ex, ey, ez);
      check_lat("busy_start", lat);
      repeat (400) @(negedge i_clk);
      n_checks++;
      if (fin_cnt - c0 !== 1) $display("FAIL busy_finished_count: %0d pulses, required 1", fin_cnt - c0);
      else n_pass++;
   endtask

   task automatic test_done_start();
      f_t a[6]; f_t ex, ey, ez; int lat, c0; bit got;
      for (int i = 0; i < 6; i++) a[i] = rnd_fe();
      model(a[0], a[1], a[2], a[3], a[4], a[5], ex, ey, ez);
      c0 = fin_cnt;
      @(negedge i_clk);
      drive(a[0], a[1], a[2], a[3], a[4], a[5]);
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      lat = 0; got = 1'b0;
      while (!got && lat < 4000) begin
         @(negedge i_clk);
         lat++;
         if (o_finished === 1'b1) got = 1'b1;
      end
      // start presented only during the DONE cycle must be dropped
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      n_checks++;
      if (!got) $display("FAIL done_timeout: no o_finished within %0d cycles, required <= 3200", lat);
      else n_pass++;
      repeat (3300) @(negedge i_clk);
      n_checks++;
      if (fin_cnt - c0 !== 1) $display("FAIL done_start_ignored: %0d pulses, required 1", fin_cnt - c0);
      else n_pass++;
      check_result("hold", o_x3, o_y3, o_z3, ex, ey, ez);
   endtask

   task automatic test_reset_mid();
      f_t a[6]; f_t rx, ry, rz, ex, ey, ez; int lat, c0;
      for (int i = 0; i < 6; i++) a[i] = rnd_fe();
      model(a[0], a[1], a[2], a[3], a[4], a[5], ex, ey, ez);
      c0 = fin_cnt;
      @(negedge i_clk);
      drive(a[0], a[1], a[2], a[3], a[4], a[5]);
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      repeat (1500) @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      check_result("reset_mid", o_x3, o_y3, o_z3, 256'd0, 256'd0, 256'd0);
      repeat (3) @(negedge i_clk);
      i_rst = 1'b1;
      repeat (3300) @(negedge i_clk);
      n_checks++;
      if (fin_cnt !== c0) $display("FAIL reset_abort: %0d pulses after abort, required 0", fin_cnt - c0);
      else n_pass++;
      run_op(a[0], a[1], a[2], a[3], a[4], a[5], rx, ry, rz, lat);
      check_result("after_reset", rx, ry, rz, ex, ey, ez);
      check_lat("after_reset", lat);
   endtask

   initial begin
      i_rst = 1'b0;
      i_start = 1'b0;
      drive(256'd0, 256'd0, 256'd0, 256'd0, 256'd0, 256'd0);
      test_reset();
      test_identity_left();
      test_identity_right();
      test_general_add();
      test_doubling();
      test_random();
      test_busy_start();
      test_done_start();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/point_add.md
# point_add

Projective-coordinate point adder on the twisted Edwards curve edwards25519 (a = −1, p = 2^255 − 19). It takes two points (X:Y:Z), computes their sum with the unified add-2008-bbjlp formula, and returns the result in projective form. It is the group-add engine of the scalar-multiplication datapath and is driven by the ladder controller through a start/finished handshake.

## Interface
- No parameters. Field constants come from the shared package.
- i_clk  in  1  single clock, rising-edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle request; operands sampled on the same edge.
- i_x1, i_y1, i_z1  in  256 each  point P1, canonical residues in [0, p).
- i_x2, i_y2, i_z2  in  256 each  point P2, canonical residues in [0, p).
- o_x3, o_y3, o_z3  out  256 each  sum P1+P2, canonical residues in [0, p).
- o_finished  out  1  one-cycle pulse when o_x3/o_y3/o_z3 are valid.

## Operation
- All arithmetic is mod p. Operands and results are plain residues, not Montgomery form. Constant d = 0x52036CEE2B6FFE738CC740797779E89800700A4D4141D8AB75EB4DCA135978A3.
- Exact sequence, so projective outputs are bit-exact:
  - A = Z1·Z2
  - B = A²
  - C = X1·X2
  - D = Y1·Y2
  - E = d·(C·D)
  - F = B − E
  - G = B + E
  - H = (X1+Y1)·(X2+Y2) − C − D
  - X3 = (A·F)·H
  - Y3 = (A·G)·(D+C)
  - Z3 = F·G
- Total of 12 modular multiplies. Add and subtract steps reduce with a single conditional ±p correction.
- FSM states:
  - IDLE: wait for i_start.
  - LOAD: latch the six operands.
  - MUL_n: issue a multiply, wait for its done, run the following add/sub.
  - DONE: write outputs, pulse o_finished, return to IDLE.
- Only one multiply is in flight at a time, on one shared multiplier.
- Inputs may change after the start cycle. Internal operand copies are used.
- i_start while busy is ignored. The current computation is not disturbed.
- Inputs ≥ p give unspecified results.
- Unified formula: P1 = P2 and the identity (0:1:1) need no special case.

## Timing
- Reset (i_rst low, asynchronous): o_x3/o_y3/o_z3 = 0, o_finished = 0, FSM = IDLE, multiplier cleared.
- Reset during a computation aborts it. No o_finished is produced.
- Latency from the i_start edge to the o_finished pulse:
  - fixed and data-independent;
  - the multiplier is bit-serial: 256 iterations plus 2 cycles of final reduction, 258 cycles per multiply;
  - total is ≤ 3200 cycles.
- o_finished is high for exactly one cycle.
- Outputs update on the same edge that raises o_finished. They hold until the next accepted computation completes.
- i_start in the DONE cycle is ignored. The earliest restart is the cycle after the o_finished pulse.

## Configuration
- POINTADD_MIXED_EN defined: mixed addition.
  - i_z2 is ignored and treated as 1.
  - A = Z1, the first multiply is skipped: 11 multiplies, latency reduced by one multiply slot.
- POINTADD_MIXED_EN undefined: full projective addition as above.
- With Z2 = 1, both builds give bit-identical outputs.

## Structure
- Package ed25519_pkg holds:
  - P_MOD and CURVE_D as 256-bit localparams;
  - the FIELD_W = 256 width;
  - the point-adder FSM state enum.
- Sub-module mod_mul:
  - interleaved shift-add bit-serial modular multiplier;
  - start/done handshake;
  - 256-bit operands, result in [0, p).
- Add/sub mod p stays inline in point_add.

## Test plan
- Identity left: (0:1:1) + (x:y:1), with x = 7075909580202862594128302673554914659407030209928197693208324339654829354926 and y = 21286769175881002626746167682496214460774588269525023793279114113306181287586 → exactly (x:y:1), o_finished pulses once.
- Identity right: (x:y:1) + (0:1:1) → exactly (x:y:1).
- Doubling and general add: P1 = (51169388680954780618255949183088705830597642531673777941256840852923233932582 : 38023371316134590270444440476521181483750022538757642829225406787274294448402 : 47908574844383975721735585330619112154511882220818545990695845831320904662833), P2 = (x:y:1) → matches the golden software model of the formula above.
  - Check bit-exact outputs and X3/Z3, Y3/Z3 on curve.
  - Also check P1 + P1 against the model.
- Handshake: pulse i_start, then change the inputs and pulse i_start again mid-computation.
  - Result reflects the first operands.
  - Exactly one o_finished.
  - Latency identical across all vectors.
- Reset mid-operation: drop i_rst halfway.
  - Outputs go to 0 immediately, no o_finished.
  - A fresh start afterwards gives the correct result.
- Build with POINTADD_MIXED_EN, rerun all vectors with Z2 = 1 → identical outputs, shorter fixed latency.
